// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: shared constants, register map and handshake state encodings for bus_timer.
package bus_timer_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam logic READ = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_CTRL = 2'd0;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_IRQ = 2'd1;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_EXPIRE = 2'd2;
    localparam logic [ADDR_W-1:0] TIMER_ADDR_COUNTER = 2'd3;
    localparam int TIMER_START_BIT = 0;
    localparam int TIMER_PERIODIC_BIT = 1;
    typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_ACK} bus_state_t;
endpackage

// File: rtl/bus_slave_if.sv
// bus_slave_if: wait-state bus responder handshake; latches a request and presents it for one ack cycle.
module bus_slave_if import bus_timer_pkg::*; #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Cs_,
    input  logic              As_,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Rdy_,
    output logic              acc_en,
    output logic              acc_rw,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_data,
    input  logic [DATA_W-1:0] rd_val
);
    bus_state_t state, next;
    logic [3:0] wait_cnt;
    logic       strobe;

    assign strobe = state == BUS_IDLE && !Cs_ && !As_;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BUS_IDLE;
            wait_cnt <= '0;
            acc_rw <= READ;
            acc_addr <= '0;
            acc_data <= '0;
        end else begin
            state <= next;
            if (strobe) begin
                wait_cnt <= 4'(WAIT_CYCLES);
                acc_rw <= RW;
                acc_addr <= Addr;
                acc_data <= WrData;
            end else if (state == BUS_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // the last WAIT cycle is the one whose count is about to reach zero
    always_comb begin
        next = state;
        if (strobe)
            next = (WAIT_CYCLES == 0) ? BUS_ACK : BUS_WAIT;
        else if (state == BUS_WAIT && wait_cnt <= 4'd1)
            next = BUS_ACK;
        else if (state == BUS_ACK)
            next = BUS_IDLE;
    end

    assign acc_en = state == BUS_ACK;
    assign Rdy_ = !acc_en;
    assign RdData = (acc_en && acc_rw == READ) ? rd_val : '0;
endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped interval timer with level interrupt, answering on the shared word bus.
module bus_timer import bus_timer_pkg::*; #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Cs_,
    input  logic              As_,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Rdy_,
    output logic              Irq
);
    logic              acc_en, acc_rw, wr, hit;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data, rd_val, ctrl_val;
    logic              start, periodic, irq_flag;
    logic [DATA_W-1:0] expire, counter;

    bus_slave_if #(.WAIT_CYCLES(WAIT_CYCLES)) u_if (
        .clk(clk), .reset(reset), .Cs_(Cs_), .As_(As_), .RW(RW), .Addr(Addr), .WrData(WrData),
        .RdData(RdData), .Rdy_(Rdy_), .acc_en(acc_en), .acc_rw(acc_rw), .acc_addr(acc_addr),
        .acc_data(acc_data), .rd_val(rd_val)
    );

    assign wr = acc_en && acc_rw == WRITE;
    assign hit = start && counter == expire;
    assign Irq = irq_flag;

    always_comb begin
        ctrl_val = '0;
        ctrl_val[TIMER_START_BIT] = start;
        ctrl_val[TIMER_PERIODIC_BIT] = periodic;
        rd_val = acc_addr == TIMER_ADDR_CTRL ? ctrl_val :
                 acc_addr == TIMER_ADDR_IRQ ? {{(DATA_W-1){1'b0}}, irq_flag} :
                 acc_addr == TIMER_ADDR_EXPIRE ? expire : counter;
    end

    // bus writes override the timer, except an expiry always sets the flag
    always_ff @(posedge clk) begin
        if (reset) begin
            start <= 1'b0;
            periodic <= 1'b0;
            irq_flag <= 1'b0;
            expire <= '0;
            counter <= '0;
        end else begin
            counter <= (wr && acc_addr == TIMER_ADDR_COUNTER) ? acc_data :
                       hit ? '0 : start ? counter + 32'd1 : counter;
            irq_flag <= hit || ((wr && acc_addr == TIMER_ADDR_IRQ) ? acc_data[0] : irq_flag);
            if (wr && acc_addr == TIMER_ADDR_CTRL) begin
                start <= acc_data[TIMER_START_BIT];
                periodic <= acc_data[TIMER_PERIODIC_BIT];
            end else if (hit && !periodic) begin
                start <= 1'b0;
            end
            if (wr && acc_addr == TIMER_ADDR_EXPIRE)
                expire <= acc_data;
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: randomized self-checking bench for bus_timer against a register-level timer model.
module tb_bus_timer;
    import bus_timer_pkg::*;
    localparam int W = 1;

    logic        clk = 1'b0, reset = 1'b1, Cs_ = 1'b1, As_ = 1'b1, RW = 1'b1;
    logic [1:0]  Addr = '0;
    logic [31:0] WrData = '0;
    logic [31:0] RdData;
    logic        Rdy_, Irq;
    int total = 0, bad = 0;

    logic        m_start = 0, m_per = 0, m_irq = 0;
    logic [31:0] m_exp = 0, m_cnt = 0;

    bus_timer #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .Cs_(Cs_), .As_(As_), .RW(RW), .Addr(Addr), .WrData(WrData),
        .RdData(RdData), .Rdy_(Rdy_), .Irq(Irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        return a == 2'd0 ? {30'b0, m_per, m_start} : a == 2'd1 ? {31'b0, m_irq} : a == 2'd2 ? m_exp : m_cnt;
    endfunction

    // advance one clock; the model applies the timer rules plus an optional committed write
    task automatic step(input bit we, input logic [1:0] a, input logic [31:0] d);
        bit hit;
        logic ns, np, ni;
        logic [31:0] ne, nc;
        hit = m_start && m_cnt == m_exp;
        ns = m_start && !(hit && !m_per);
        np = m_per;
        ni = m_irq || hit;
        ne = m_exp;
        nc = hit ? 32'd0 : m_start ? m_cnt + 32'd1 : m_cnt;
        if (we) begin
            case (a)
                2'd0: {np, ns} = d[1:0];
                2'd1: ni = hit || d[0];
                2'd2: ne = d;
                default: nc = d;
            endcase
        end
        if (reset) begin
            {ns, np, ni} = 3'b0;
            ne = 0;
            nc = 0;
        end
        @(posedge clk);
        #1;
        m_start = ns; m_per = np; m_irq = ni; m_exp = ne; m_cnt = nc;
    endtask

    // one complete bus access; ok reports whether the handshake shape was right
    task automatic access(input logic rw, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic [31:0] mrd, output bit ok);
        Cs_ = 0; As_ = 0; RW = rw; Addr = a; WrData = d; ok = 1;
        step(0, 0, 0);
        repeat (W) begin
            if (Rdy_ !== 1'b1 || RdData !== 0) ok = 0;
            step(0, 0, 0);
        end
        if (Rdy_ !== 1'b0) ok = 0;
        if (rw == WRITE && RdData !== 0) ok = 0;
        rd = RdData;
        mrd = m_read(a);
        step(rw == WRITE, a, d);
        Cs_ = 1; As_ = 1;
        if (Rdy_ !== 1'b1 || RdData !== 0) ok = 0;
    endtask

    task automatic test_reset;
        logic [31:0] rd, mrd;
        bit ok;
        reset = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 0;
        total++; if (Rdy_ !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", Rdy_); end
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", Irq); end
        total++; if (RdData !== 0) begin bad++; $display("FAIL reset_rddata got=%h exp=0", RdData); end
        access(READ, 2'd3, 0, rd, mrd, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_read_shape got=bad exp=good"); end
        total++; if (rd !== 0) begin bad++; $display("FAIL reset_counter got=%h exp=0", rd); end
    endtask

    task automatic test_handshake;
        logic [31:0] rd, mrd;
        bit ok;
        int lows;
        access(WRITE, 2'd2, 32'd5, rd, mrd, ok);
        total++; if (!ok) begin bad++; $display("FAIL hs_write_shape got=bad exp=good"); end
        access(READ, 2'd2, 0, rd, mrd, ok);
        total++; if (!ok || rd !== 32'h5) begin bad++; $display("FAIL hs_read_expire got=%h ok=%0d exp=00000005", rd, ok); end
        Cs_ = 0; As_ = 0; RW = READ; Addr = 2'd2;
        step(0, 0, 0);
        Cs_ = 1; As_ = 1;
        repeat (W) step(0, 0, 0);
        total++; if (Rdy_ !== 1'b0 || RdData !== 32'h5) begin bad++; $display("FAIL hs_drop_as got rdy=%b data=%h exp rdy=0 data=5", Rdy_, RdData); end
        step(0, 0, 0);
        Cs_ = 1; As_ = 0; lows = 0;
        repeat (6) begin
            step(0, 0, 0);
            if (Rdy_ !== 1'b1) lows++;
        end
        As_ = 1;
        total++; if (lows != 0) begin bad++; $display("FAIL hs_no_cs got=%0d acks exp=0", lows); end
    endtask

    task automatic test_oneshot;
        logic [31:0] rd, mrd;
        bit ok;
        int rise, mism;
        access(WRITE, 2'd2, 32'd3, rd, mrd, ok);
        access(WRITE, 2'd0, 32'h1, rd, mrd, ok);
        rise = 0; mism = 0;
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0);
            if (Irq !== m_irq) mism++;
            if (rise == 0 && Irq === 1'b1) rise = k;
        end
        total++; if (rise != 4) begin bad++; $display("FAIL oneshot_rise got=%0d exp=4", rise); end
        total++; if (mism != 0) begin bad++; $display("FAIL oneshot_irq_track got=%0d diffs exp=0", mism); end
        access(READ, 2'd0, 0, rd, mrd, ok);
        total++; if (rd !== 0 || !ok) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=0", rd); end
        access(READ, 2'd3, 0, rd, mrd, ok);
        total++; if (rd !== 0 || !ok) begin bad++; $display("FAIL oneshot_counter got=%h exp=0", rd); end
    endtask

    task automatic test_periodic;
        logic [31:0] rd, mrd;
        bit ok;
        int rise;
        access(WRITE, 2'd1, 32'd0, rd, mrd, ok);
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL per_clear_idle got=%b exp=0", Irq); end
        access(WRITE, 2'd2, 32'd2, rd, mrd, ok);
        access(WRITE, 2'd0, 32'h3, rd, mrd, ok);
        rise = 0;
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 0);
            if (rise == 0 && Irq === 1'b1) rise = k;
        end
        total++; if (rise != 3) begin bad++; $display("FAIL per_rise got=%0d exp=3", rise); end
        while (((m_cnt + W + 1) % 3) != 0) step(0, 0, 0);
        access(WRITE, 2'd1, 32'd0, rd, mrd, ok);
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL per_clear got=%b exp=0", Irq); end
        step(0, 0, 0);
        step(0, 0, 0);
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL per_reset_again got=%b exp=1", Irq); end
        while (((m_cnt + W + 1) % 3) != 2) step(0, 0, 0);
        access(WRITE, 2'd1, 32'd0, rd, mrd, ok);
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL per_set_wins got=%b exp=1", Irq); end
    endtask

    task automatic test_collision;
        logic [31:0] rd, mrd;
        bit ok;
        while (((m_cnt + W + 1) % 3) != 2) step(0, 0, 0);
        access(WRITE, 2'd3, 32'h100, rd, mrd, ok);
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL coll_irq got=%b exp=1", Irq); end
        access(READ, 2'd3, 0, rd, mrd, ok);
        total++; if (rd !== 32'h100 + W + 1) begin bad++; $display("FAIL coll_counter got=%h exp=%h", rd, 32'h100 + W + 1); end
        access(WRITE, 2'd0, 32'h0, rd, mrd, ok);
        access(READ, 2'd3, 0, rd, mrd, ok);
        total++; if (rd !== mrd) begin bad++; $display("FAIL coll_stopped got=%h exp=%h", rd, mrd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, mrd, d;
        logic [1:0] a;
        logic rw;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3));
            d = a == 2'd2 ? $urandom_range(0, 6) : a == 2'd3 ? $urandom_range(0, 8) :
                a == 2'd0 ? $urandom_range(0, 3) : $urandom;
            access(rw, a, d, rd, mrd, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_shape_%0d got=bad exp=good", i); end
            if (rw == READ) begin
                total++; if (rd !== mrd) begin bad++; $display("FAIL rand_read_%0d addr=%0d got=%h exp=%h", i, a, rd, mrd); end
            end
            total++; if (Irq !== m_irq) begin bad++; $display("FAIL rand_irq_%0d got=%b exp=%b", i, Irq, m_irq); end
            repeat ($urandom_range(0, 3)) step(0, 0, 0);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, mrd;
        bit ok;
        int lows;
        Cs_ = 0; As_ = 0; RW = WRITE; Addr = 2'd2; WrData = 32'h55;
        step(0, 0, 0);
        reset = 1; Cs_ = 1; As_ = 1; lows = 0;
        repeat (3) begin
            step(0, 0, 0);
            if (Rdy_ !== 1'b1) lows++;
        end
        reset = 0;
        repeat (2) begin
            step(0, 0, 0);
            if (Rdy_ !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL mid_no_ack got=%0d acks exp=0", lows); end
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", Irq); end
        access(READ, 2'd2, 0, rd, mrd, ok);
        total++; if (!ok || rd !== 0) begin bad++; $display("FAIL mid_expire got=%h ok=%0d exp=0", rd, ok); end
        access(READ, 2'd0, 0, rd, mrd, ok);
        total++; if (rd !== 0) begin bad++; $display("FAIL mid_ctrl got=%h exp=0", rd); end
        access(READ, 2'd3, 0, rd, mrd, ok);
        total++; if (rd !== 0) begin bad++; $display("FAIL mid_counter got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_oneshot();
        test_periodic();
        test_collision();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
